cc_fill_seq: RTL
================

// Module: cc_fill_seq
// PURPOSE
//  Refill sequencer for the combined code cache: the writer side of its fill/invalidate port.
//  Accepts one line-miss at a time and probes chkCL to drop redundant fills.
//  Fetches a 1040b line (4 beats of 260b) from the bus, then drives the cache's 2-cycle half-line write.
//  Also issues single-cycle invalidates. Sits between the fetch-miss logic and the L2/bus interface.
// PARAMETERS
//  IP_WIDTH   44   instruction address width; line address = IP[43:5]
//  BEAT_W     260  bus response beat width (4 beats per line)
//  CHK_LAT    1    cycles from chkCL_clkEn to valid chkCL_hit (1..3)
// PORTS
//  clk           in   1     clock
//  rst           in   1     reset: synchronous, active-high
//  miss_valid    in   1     miss request
//  miss_ready    out  1     accepted when valid&ready
//  miss_IP       in   44    missing IP (low 5 bits ignored)
//  inv_valid     in   1     invalidate request
//  inv_ready     out  1     accepted when valid&ready
//  inv_IP        in   44    line to invalidate
//  bus_req_valid out  1     line read request
//  bus_req_ready in   1     bus accepts request
//  bus_req_addr  out  39    line address IP[43:5]
//  bus_rsp_valid in   1     response beat valid (no backpressure)
//  bus_rsp_data  in   260   beat data, beat 0 first
//  bus_rsp_err   in   1     beat error flag (used only with CC_FILL_ERR_EN)
//  chkCL_IP      out  44    probe address
//  chkCL_clkEn   out  1     probe strobe
//  chkCL_hit     in   1     probe result, CHK_LAT cycles after strobe
//  write_IP      out  44    cache write/invalidate address
//  cc_write_wen  out  1     first-half write strobe
//  cc_invalidate out  1     invalidate strobe
//  write_data    out  520   half line: low half in the wen cycle, high half in the next cycle
//  fill_done     out  1     pulse: miss retired
//  fill_drop     out  1     with fill_done: line already present, no write
//  fill_err      out  1     with fill_done: bus error, line invalidated (CC_FILL_ERR_EN only)
// BEHAVIOUR
//  - Reset: all outputs 0; miss_ready=inv_ready=0 during rst; FSM=IDLE; beat counter=0.
//  - FSM states and transitions:
//    IDLE: miss_ready=inv_ready=1 when no invalidate is pending.
//    IDLE, inv_valid: inv has priority over miss. Next cycle: cc_invalidate=1, write_IP=inv_IP, then IDLE.
//    IDLE, miss accepted: latch IP; -> CHK.
//    CHK: chkCL_clkEn=1 for exactly 1 cycle, chkCL_IP=latched IP. Wait CHK_LAT cycles, sample chkCL_hit.
//         hit -> fill_done=fill_drop=1, -> IDLE. miss -> REQ.
//    REQ: bus_req_valid=1 held until bus_req_ready; addr stable while valid; -> RX.
//    RX: each bus_rsp_valid stores the beat at index cnt[1:0]; after beat 3 -> WR0. Beats outside RX are ignored.
//    WR0: cc_write_wen=1, write_IP=line IP, write_data=beats{1,0}.
//    WR1: cc_write_wen=0, write_data=beats{3,2}, write_IP held; fill_done=1; -> IDLE.
//  - Spacing: cc_write_wen is never high on 2 consecutive cycles.
//  - Spacing: cc_invalidate is never asserted in the cycle after cc_write_wen.
//  - Spacing: cc_write_wen and cc_invalidate are never asserted together.
//  - Latency: miss accept -> cc_write_wen >= 3+CHK_LAT cycles plus bus time.
//  - Latency: inv accept -> cc_invalidate in the next cycle.
//  - rst mid-fill: abandon in 1 cycle; no wen/invalidate/fill_done emitted.
//    Late bus beats after rst land in IDLE and are ignored.
//  - write_data is 0 outside WR0/WR1.
// CONFIGURATION
//  CC_FILL_ERR_EN defined:
//   - any bus_rsp_err in the line sets a sticky flag, cleared on leaving RX.
//   - flag set: WR0 issues cc_invalidate instead of cc_write_wen; WR1 pulses fill_done=fill_err=1.
//  CC_FILL_ERR_EN undefined: bus_rsp_err ignored; fill_err tied 0.
// STRUCTURE
//  - Shared package: cc_fill_state_t enum (IDLE,INV,CHK,REQ,RX,WR0,WR1); CC_LINE_W=1040; CC_HALF_W=520; CC_LADDR_W=39.
//  - One sub-module: cc_fill_linebuf (4x260b beat store plus beat counter, write-by-index, half-select read).
// TESTING
//  1 miss_IP=0x123_4567_89A0, chkCL_hit=0, 4 beats B0..B3 -> bus_req_addr=IP[43:5]; wen 1 cycle with {B1,B0}; next cycle {B3,B2}; fill_done.
//  2 miss with chkCL_hit=1 -> no bus_req_valid, no wen; fill_done=fill_drop=1 at CHK+CHK_LAT.
//  3 inv_valid and miss_valid in the same IDLE cycle -> cc_invalidate first (write_IP=inv_IP); miss accepted 1 cycle later.
//  4 bus_req_ready held low 5 cycles -> bus_req_valid and addr stable; beats with gaps (valid 1,0,1,0,1,1) -> correct assembly.
//  5 rst asserted after beat 2 -> outputs 0 next cycle; a late beat 3 is ignored; the next miss fills correctly.
//  6 CC_FILL_ERR_EN, bus_rsp_err on beat 1 -> cc_invalidate at WR0, no wen, fill_err=1; undefined -> normal write.

Source files
------------

// File: rtl/cc_fill_pkg.sv
// Shared types and widths for the code-cache refill sequencer.
package cc_fill_pkg;

  typedef enum logic [2:0] {IDLE, INV, CHK, REQ, RX, WR0, WR1} cc_fill_state_t;

  localparam int CC_IP_W    = 44;
  localparam int CC_BEAT_W  = 260;
  localparam int CC_LINE_W  = 1040;
  localparam int CC_HALF_W  = 520;
  localparam int CC_LADDR_W = 39;

  // Line-aligned IP: byte offset within the 32B line cleared.
  function automatic logic [CC_IP_W-1:0] cc_line_ip(input logic [CC_IP_W-1:0] ip);
    return ip & ~CC_IP_W'(5'h1f);
  endfunction

endpackage

// File: rtl/cc_fill_linebuf.sv
// Four-beat line store: beats written in arrival order by an internal counter, read back one half-line at a time.
module cc_fill_linebuf
  import cc_fill_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [CC_BEAT_W-1:0] wr_data,
  input  logic                 half_sel,
  output logic                 last_beat,
  output logic [CC_HALF_W-1:0] rd_half
);

  logic [CC_BEAT_W-1:0] beat_q [4];
  logic [CC_BEAT_W-1:0] beat_d [4];
  logic [1:0]           cnt_q, cnt_d;

  always_comb begin
    beat_d = beat_q;
    cnt_d  = cnt_q;
    if (wr_en) begin
      beat_d[cnt_q] = wr_data;
      cnt_d         = cnt_q + 2'd1;
    end
  end

  // Beat data needs no reset; only the counter decides what is valid.
  always_ff @(posedge clk) begin
    beat_q <= beat_d;
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last_beat = (cnt_q == 2'd3);
  assign rd_half   = half_sel ? {beat_q[3], beat_q[2]} : {beat_q[1], beat_q[0]};

endmodule

// File: rtl/cc_fill_seq.sv
// Code-cache refill sequencer: probe, bus line fetch, 2-cycle half-line write, single-cycle invalidates.
// Optional CC_FILL_ERR_EN: a bus error on any beat turns the write into an invalidate and reports fill_err.
module cc_fill_seq
  import cc_fill_pkg::*;
#(
  parameter int CHK_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [CC_IP_W-1:0]    miss_IP,
  input  logic                  inv_valid,
  output logic                  inv_ready,
  input  logic [CC_IP_W-1:0]    inv_IP,
  output logic                  bus_req_valid,
  input  logic                  bus_req_ready,
  output logic [CC_LADDR_W-1:0] bus_req_addr,
  input  logic                  bus_rsp_valid,
  input  logic [CC_BEAT_W-1:0]  bus_rsp_data,
  input  logic                  bus_rsp_err,
  output logic [CC_IP_W-1:0]    chkCL_IP,
  output logic                  chkCL_clkEn,
  input  logic                  chkCL_hit,
  output logic [CC_IP_W-1:0]    write_IP,
  output logic                  cc_write_wen,
  output logic                  cc_invalidate,
  output logic [CC_HALF_W-1:0]  write_data,
  output logic                  fill_done,
  output logic                  fill_drop,
  output logic                  fill_err
);

  cc_fill_state_t       state_q, state_d;
  logic [CC_IP_W-1:0]   ip_q, ip_d, write_ip_q, write_ip_d;
  logic [1:0]           chk_cnt_q, chk_cnt_d;
  logic                 chk_clken_q, chk_clken_d, bus_req_valid_q, bus_req_valid_d;
  logic                 wen_q, wen_d, inv_q, inv_d;
  logic                 done_q, done_d, drop_q, drop_d, ferr_q, ferr_d;
  logic [CC_HALF_W-1:0] wdata_q, wdata_d;
  logic                 lb_wr, lb_last, err_now;
  logic [CC_HALF_W-1:0] lb_half;

  assign lb_wr = (state_q == RX) && bus_rsp_valid;

  cc_fill_linebuf u_linebuf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (lb_wr),
    .wr_data   (bus_rsp_data),
    .half_sel  (state_q == WR0),
    .last_beat (lb_last),
    .rd_half   (lb_half)
  );

`ifdef CC_FILL_ERR_EN
  logic err_q, err_d;
  always_comb begin
    err_d = err_q;
    if (state_q == RX) err_d = (lb_wr && lb_last) ? 1'b0 : err_now;
  end
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err_now = err_q | (lb_wr & bus_rsp_err);
`else
  logic unused_bus_err;
  assign unused_bus_err = bus_rsp_err;
  assign err_now        = 1'b0;
`endif

  // A pending invalidate blocks miss acceptance so it always wins the IDLE slot.
  assign inv_ready  = !rst && (state_q == IDLE);
  assign miss_ready = inv_ready && !inv_valid;

  always_comb begin
    state_d         = state_q;
    ip_d            = ip_q;
    chk_cnt_d       = chk_cnt_q;
    write_ip_d      = '0;
    wdata_d         = '0;
    chk_clken_d     = 1'b0;
    bus_req_valid_d = 1'b0;
    wen_d           = 1'b0;
    inv_d           = 1'b0;
    done_d          = 1'b0;
    drop_d          = 1'b0;
    ferr_d          = 1'b0;
    case (state_q)
      IDLE: begin
        if (inv_valid && inv_ready) begin
          state_d    = INV;
          inv_d      = 1'b1;
          write_ip_d = inv_IP;
        end else if (miss_valid && miss_ready) begin
          state_d     = CHK;
          ip_d        = cc_line_ip(miss_IP);
          chk_clken_d = 1'b1;
          chk_cnt_d   = '0;
        end
      end
      INV: state_d = IDLE;
      CHK: begin
        if (chk_cnt_q == 2'(CHK_LAT)) begin
          if (chkCL_hit) begin
            state_d = IDLE;
            done_d  = 1'b1;
            drop_d  = 1'b1;
          end else begin
            state_d         = REQ;
            bus_req_valid_d = 1'b1;
          end
        end else begin
          chk_cnt_d = chk_cnt_q + 2'd1;
        end
      end
      REQ: begin
        if (bus_req_ready) state_d = RX;
        else               bus_req_valid_d = 1'b1;
      end
      RX: begin
        if (lb_wr && lb_last) begin
          state_d    = WR0;
          wen_d      = !err_now;
          inv_d      = err_now;
          write_ip_d = ip_q;
          wdata_d    = lb_half;
        end
      end
      WR0: begin
        state_d    = WR1;
        write_ip_d = write_ip_q;
        wdata_d    = lb_half;
        done_d     = 1'b1;
`ifdef CC_FILL_ERR_EN
        ferr_d     = inv_q;
`endif
      end
      WR1:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      ip_q            <= '0;
      chk_cnt_q       <= '0;
      write_ip_q      <= '0;
      wdata_q         <= '0;
      chk_clken_q     <= 1'b0;
      bus_req_valid_q <= 1'b0;
      wen_q           <= 1'b0;
      inv_q           <= 1'b0;
      done_q          <= 1'b0;
      drop_q          <= 1'b0;
      ferr_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      ip_q            <= ip_d;
      chk_cnt_q       <= chk_cnt_d;
      write_ip_q      <= write_ip_d;
      wdata_q         <= wdata_d;
      chk_clken_q     <= chk_clken_d;
      bus_req_valid_q <= bus_req_valid_d;
      wen_q           <= wen_d;
      inv_q           <= inv_d;
      done_q          <= done_d;
      drop_q          <= drop_d;
      ferr_q          <= ferr_d;
    end
  end

  assign chkCL_IP      = ip_q;
  assign chkCL_clkEn   = chk_clken_q;
  assign bus_req_valid = bus_req_valid_q;
  assign bus_req_addr  = ip_q[CC_IP_W-1:5];
  assign write_IP      = write_ip_q;
  assign cc_write_wen  = wen_q;
  assign cc_invalidate = inv_q;
  assign write_data    = wdata_q;
  assign fill_done     = done_q;
  assign fill_drop     = drop_q;
  assign fill_err      = ferr_q;

endmodule
